// File: rtl/bfp16_pkg.sv
// -----------------------------------------------------------------------------
// bfp16_pkg
// Shared constants, FSM state type and helpers for the bfp16 PE-column
// scheduler (bfp16_col_sched) and its lane skew buffer (bfp16_skew_buf).
// -----------------------------------------------------------------------------
package bfp16_pkg;

  localparam int DATA_TYPE = 16;  // element width (bfp16)
  localparam int LANES     = 8;   // PE column depth / ifmap lanes / weight vector length
  localparam int MAX_ROWS  = 16;  // maximum rows per job

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Row count actually processed: requested rows capped at the job limit.
  function automatic logic [4:0] clamp_rows(input logic [4:0] req, input logic [4:0] lim);
    if (req > lim) begin
      return lim;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/bfp16_skew_buf.sv
// -----------------------------------------------------------------------------
// bfp16_skew_buf
// Diagonal skew for the ifmap row bus: lane k is delayed by k register stages
// so that element k of a row reaches PE k one cycle after element k-1.
// Lane 0 occupies the MSBs of both buses.
//
// Ports:
//   clk       clock
//   clear     synchronous clear of every delay stage
//   in_valid  in_data carries a real row this cycle; otherwise zeros enter
//   in_data   unskewed row, LANES x DATA_TYPE
//   out_data  skewed row, LANES x DATA_TYPE
// -----------------------------------------------------------------------------
module bfp16_skew_buf #(
  parameter int LANES     = 8,
  parameter int DATA_TYPE = 16
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [LANES*DATA_TYPE-1:0]   in_data,
  output logic [LANES*DATA_TYPE-1:0]   out_data
);

  logic [LANES*DATA_TYPE-1:0] gated_s;

  // Blank the row bus on cycles without fresh read data so idle slots read 0
  always_comb begin
    if (in_valid) begin
      gated_s = in_data;
    end else begin
      gated_s = {(LANES*DATA_TYPE){1'b0}};
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int LO = (LANES - 1 - k) * DATA_TYPE;

    if (k == 0) begin : g_direct
      assign out_data[LO +: DATA_TYPE] = gated_s[LO +: DATA_TYPE];
    end else begin : g_delay
      logic [DATA_TYPE-1:0] dly_r [k];

      // k-stage shift register for lane k
      always_ff @(posedge clk) begin
        if (clear) begin
          for (int s = 0; s < k; s++) begin
            dly_r[s] <= {DATA_TYPE{1'b0}};
          end
        end else begin
          dly_r[0] <= gated_s[LO +: DATA_TYPE];
          for (int s = 1; s < k; s++) begin
            dly_r[s] <= dly_r[s-1];
          end
        end
      end

      assign out_data[LO +: DATA_TYPE] = dly_r[k-1];
    end
  end

endmodule

// File: rtl/bfp16_col_sched.sv
// -----------------------------------------------------------------------------
// bfp16_col_sched
// Job scheduler for one bfp16 PE column. For a job of M rows it serially
// loads LANES weights into the column, streams M ifmap rows through a lane
// skew buffer, and collects one column result per row.
//
// Job timeline (S = cycle start is accepted in IDLE):
//   S+j       w_addr = j (j = 0..LANES-1); data returns one cycle later and is
//             forwarded on pe_weight with pe_ctrl = 0
//   S+8+r     x_rd_en, x_addr = r
//   S+9+r+k   element k of row r on pe_ifmap lane k
//   S+16+r+OUT_LAT  res_valid, res_idx = r, res_data = pe_out
//   last result + 1: done pulse, then back to IDLE
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, num_rows     job request and requested row count (capped at MAX_ROWS)
//   busy, done          job in progress; one-cycle completion pulse
//   w_addr, w_data      weight buffer read port (1-cycle latency)
//   x_rd_en, x_addr,    ifmap row buffer read port (1-cycle latency)
//   x_data
//   pe_ctrl             0 = weight load, 1 = compute
//   pe_weight           serial weight to the column
//   pe_ifmap            skewed ifmap row to the column
//   pe_out              column result
//   res_valid, res_idx, result strobe, row index and value
//   res_data
//   perf_cycles         busy-cycle counter, only when BFP16_COL_SCHED_PERF_EN
//                       is defined
// -----------------------------------------------------------------------------
module bfp16_col_sched #(
  parameter int DATA_TYPE = bfp16_pkg::DATA_TYPE,
  parameter int LANES     = bfp16_pkg::LANES,
  parameter int MAX_ROWS  = bfp16_pkg::MAX_ROWS,
  parameter int OUT_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [4:0]                    num_rows,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(LANES)-1:0]      w_addr,
  input  logic [DATA_TYPE-1:0]          w_data,
  output logic                          x_rd_en,
  output logic [$clog2(MAX_ROWS)-1:0]   x_addr,
  input  logic [LANES*DATA_TYPE-1:0]    x_data,
  output logic                          pe_ctrl,
  output logic [DATA_TYPE-1:0]          pe_weight,
  output logic [LANES*DATA_TYPE-1:0]    pe_ifmap,
  input  logic [DATA_TYPE-1:0]          pe_out,
  output logic                          res_valid,
  output logic [$clog2(MAX_ROWS)-1:0]   res_idx,
  output logic [DATA_TYPE-1:0]          res_data
`ifdef BFP16_COL_SCHED_PERF_EN
  ,
  output logic [15:0]                   perf_cycles
`endif
);

  import bfp16_pkg::*;

  localparam int WAW   = $clog2(LANES);
  localparam int XAW   = $clog2(MAX_ROWS);
  localparam int LAT_W = $clog2(LANES + OUT_LAT + 1);
  localparam logic [WAW-1:0]   W_LAST   = WAW'(LANES - 1);
  // Cycles from the first row read to the cycle before its result strobe.
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LANES + OUT_LAT - 1);
  localparam logic [4:0]       ROW_LIM  = 5'(MAX_ROWS);

  state_t               state_r;
  logic [4:0]           m_r;
  logic [4:0]           res_cnt_r;
  logic [LAT_W-1:0]     lat_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 wload_r;
  logic                 x_rd_en_r;
  logic                 xv_r;
  logic                 pe_ctrl_r;
  logic                 res_valid_r;
  logic [WAW-1:0]       w_addr_r;
  logic [XAW-1:0]       x_addr_r;
  logic [XAW-1:0]       res_idx_r;

  logic [4:0]           m_start_s;
  logic                 row_last_s;
  logic                 res_last_s;
  logic                 in_flight_s;
  logic                 res_fire_s;
  logic [DATA_TYPE-1:0] pe_weight_s;
  logic [DATA_TYPE-1:0] res_data_s;

  assign m_start_s   = clamp_rows(num_rows, ROW_LIM);
  assign row_last_s  = ((5'(x_addr_r) + 5'd1) == m_r);
  assign res_last_s  = ((5'(res_idx_r) + 5'd1) == m_r);
  assign in_flight_s = (state_r == STREAM) || (state_r == DRAIN);
  // Rows are read back-to-back, so once the first result is due the rest
  // follow on consecutive cycles until all M have been issued.
  assign res_fire_s  = in_flight_s && (lat_r == LAT_LAST) && (res_cnt_r < m_r);

  // Job FSM with all control outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      m_r         <= 5'd0;
      res_cnt_r   <= 5'd0;
      lat_r       <= {LAT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wload_r     <= 1'b0;
      x_rd_en_r   <= 1'b0;
      xv_r        <= 1'b0;
      pe_ctrl_r   <= 1'b0;
      res_valid_r <= 1'b0;
      w_addr_r    <= {WAW{1'b0}};
      x_addr_r    <= {XAW{1'b0}};
      res_idx_r   <= {XAW{1'b0}};
    end else begin
      done_r      <= 1'b0;
      wload_r     <= 1'b0;
      res_valid_r <= 1'b0;
      xv_r        <= x_rd_en_r;

      if (in_flight_s && (lat_r != LAT_LAST)) begin
        lat_r <= lat_r + LAT_W'(1);
      end

      if (res_fire_s) begin
        res_valid_r <= 1'b1;
        res_idx_r   <= res_cnt_r[XAW-1:0];
        res_cnt_r   <= res_cnt_r + 5'd1;
      end

      case (state_r)
        IDLE: begin
          busy_r    <= 1'b0;
          pe_ctrl_r <= 1'b0;
          x_rd_en_r <= 1'b0;
          w_addr_r  <= {WAW{1'b0}};
          x_addr_r  <= {XAW{1'b0}};
          if (start) begin
            busy_r    <= 1'b1;
            m_r       <= m_start_s;
            lat_r     <= {LAT_W{1'b0}};
            res_cnt_r <= 5'd0;
            res_idx_r <= {XAW{1'b0}};
            if (m_start_s == 5'd0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              // Address 0 was already on the bus during the start cycle.
              state_r  <= LOAD_W;
              w_addr_r <= WAW'(1);
              wload_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        LOAD_W: begin
          // Still forwarding: the read for this cycle's address returns next cycle.
          wload_r <= 1'b1;
          if (w_addr_r == W_LAST) begin
            state_r   <= STREAM;
            w_addr_r  <= {WAW{1'b0}};
            x_rd_en_r <= 1'b1;
            x_addr_r  <= {XAW{1'b0}};
          end else begin
            w_addr_r <= w_addr_r + WAW'(1);
          end
        end

        STREAM: begin
          pe_ctrl_r <= 1'b1;
          if (row_last_s) begin
            state_r   <= DRAIN;
            x_rd_en_r <= 1'b0;
            x_addr_r  <= {XAW{1'b0}};
          end else begin
            x_addr_r <= x_addr_r + XAW'(1);
          end
        end

        DRAIN: begin
          if (res_valid_r && res_last_s) begin
            state_r   <= DONE;
            done_r    <= 1'b1;
            pe_ctrl_r <= 1'b0;
          end else begin
            pe_ctrl_r <= 1'b1;
          end
        end

        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Weight bus carries buffer data only during the load window
  always_comb begin
    if (wload_r) begin
      pe_weight_s = w_data;
    end else begin
      pe_weight_s = {DATA_TYPE{1'b0}};
    end
  end

  // Result value is only meaningful on the strobe cycle
  always_comb begin
    if (res_valid_r) begin
      res_data_s = pe_out;
    end else begin
      res_data_s = {DATA_TYPE{1'b0}};
    end
  end

  bfp16_skew_buf #(
    .LANES     (LANES),
    .DATA_TYPE (DATA_TYPE)
  ) u_skew (
    .clk      (clk),
    .clear    (rst),
    .in_valid (xv_r),
    .in_data  (x_data),
    .out_data (pe_ifmap)
  );

`ifdef BFP16_COL_SCHED_PERF_EN
  logic [15:0] perf_r;

  // Busy-cycle counter: cleared on accepted start, saturating, held when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_r <= 16'h0000;
    end else if ((state_r == IDLE) && start) begin
      perf_r <= 16'h0000;
    end else if (busy_r && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'h0001;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_cycles = perf_r;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign w_addr    = w_addr_r;
  assign x_rd_en   = x_rd_en_r;
  assign x_addr    = x_addr_r;
  assign pe_ctrl   = pe_ctrl_r;
  assign pe_weight = pe_weight_s;
  assign res_valid = res_valid_r;
  assign res_idx   = res_idx_r;
  assign res_data  = res_data_s;

endmodule

// File: tb/tb_bfp16_col_sched.sv
// -----------------------------------------------------------------------------
// tb_bfp16_col_sched
// Directed bench for bfp16_col_sched: buffer models with 1-cycle reads and a
// skewed PE-column reference model built on real arithmetic.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bfp16_col_sched;

  localparam int LANES = 8;
  localparam int DW    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        num_rows;
  logic              busy;
  logic              done;
  logic [2:0]        w_addr;
  logic [DW-1:0]     w_data;
  logic              x_rd_en;
  logic [3:0]        x_addr;
  logic [LANES*DW-1:0] x_data;
  logic              pe_ctrl;
  logic [DW-1:0]     pe_weight;
  logic [LANES*DW-1:0] pe_ifmap;
  logic [DW-1:0]     pe_out;
  logic              res_valid;
  logic [3:0]        res_idx;
  logic [DW-1:0]     res_data;
`ifdef BFP16_COL_SCHED_PERF_EN
  logic [15:0]       perf_cycles;
`endif

  int vecs = 0;
  int errs = 0;

  logic [DW-1:0]       wmem [8];
  logic [LANES*DW-1:0] xmem [16];

  always #5 clk = ~clk;

  bfp16_col_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .x_rd_en   (x_rd_en),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .pe_ctrl   (pe_ctrl),
    .pe_weight (pe_weight),
    .pe_ifmap  (pe_ifmap),
    .pe_out    (pe_out),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_data  (res_data)
`ifdef BFP16_COL_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  // Buffers with one-cycle read latency; unread ifmap cycles return junk
  always @(posedge clk) begin
    w_data <= wmem[w_addr];
    if (x_rd_en) x_data <= xmem[x_addr];
    else         x_data <= {8{16'hBEEF}};
  end

  function automatic real bf2r(input logic [15:0] b);
    logic [63:0] d;
    if (b[14:7] == 8'd0) return 0.0;
    d = {b[15], 11'(int'(b[14:7]) - 127 + 1023), b[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 16'h0000;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:45]};
  endfunction

  // Reference PE column: serial weight shift, skewed partial sums, OUT_LAT = 2
  real         wq [8];
  real         ps [8];
  logic [15:0] pe_out_r = 16'h0000;
  always @(posedge clk) begin
    if (!pe_ctrl) begin
      for (int i = 0; i < 7; i++) wq[i] <= wq[i+1];
      wq[7] <= bf2r(pe_weight);
    end
    ps[0] <= bf2r(pe_ifmap[(LANES-1)*DW +: DW]) * wq[0];
    for (int k = 1; k < LANES; k++)
      ps[k] <= ps[k-1] + bf2r(pe_ifmap[(LANES-1-k)*DW +: DW]) * wq[k];
    pe_out_r <= r2bf(ps[7]);
  end
  assign pe_out = pe_out_r;

  task automatic fill_ones();
    for (int i = 0; i < 8; i++)  wmem[i] = 16'h3f80;
    for (int r = 0; r < 16; r++) xmem[r] = {8{16'h3f80}};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_rows = 5'd0;
    repeat (3) @(negedge clk);
    vecs++; if ({busy, done, x_rd_en, pe_ctrl, res_valid} !== 5'b00000) begin
      errs++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, x_rd_en, pe_ctrl, res_valid});
    end
    vecs++; if ({w_addr, x_addr, res_idx} !== 11'd0) begin
      errs++; $display("FAIL reset_addr: got %h want 000", {w_addr, x_addr, res_idx});
    end
    vecs++; if ({pe_weight, res_data} !== 32'h0) begin
      errs++; $display("FAIL reset_data: got %h want 00000000", {pe_weight, res_data});
    end
    vecs++; if (pe_ifmap !== 128'h0) begin
      errs++; $display("FAIL reset_ifmap: got %h want 0", pe_ifmap);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    logic e;
    fill_ones();
    num_rows = 5'd4; start = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) begin @(negedge clk); start = 1'b0; end
      e = (i >= 1 && i <= 22);
      vecs++; if (busy !== e) begin errs++; $display("FAIL ones_busy c%0d: got %b want %b", i, busy, e); end
      e = (i == 22);
      vecs++; if (done !== e) begin errs++; $display("FAIL ones_done c%0d: got %b want %b", i, done, e); end
      e = (i >= 9 && i <= 21);
      vecs++; if (pe_ctrl !== e) begin errs++; $display("FAIL ones_pe_ctrl c%0d: got %b want %b", i, pe_ctrl, e); end
      e = (i >= 18 && i <= 21);
      vecs++; if (res_valid !== e) begin errs++; $display("FAIL ones_res_valid c%0d: got %b want %b", i, res_valid, e); end
      if (e) begin
        vecs++; if (res_idx !== 4'(i - 18)) begin errs++; $display("FAIL ones_res_idx c%0d: got %0d want %0d", i, res_idx, i - 18); end
        vecs++; if (res_data !== 16'h4100) begin errs++; $display("FAIL ones_res_data c%0d: got %h want 4100", i, res_data); end
      end
      e = (i >= 8 && i <= 11);
      vecs++; if (x_rd_en !== e) begin errs++; $display("FAIL ones_x_rd_en c%0d: got %b want %b", i, x_rd_en, e); end
      if (e) begin
        vecs++; if (x_addr !== 4'(i - 8)) begin errs++; $display("FAIL ones_x_addr c%0d: got %0d want %0d", i, x_addr, i - 8); end
      end
      if (i <= 7) begin
        vecs++; if (w_addr !== 3'(i)) begin errs++; $display("FAIL ones_w_addr c%0d: got %0d want %0d", i, w_addr, i); end
      end
      vecs++; if (pe_weight !== ((i >= 1 && i <= 8) ? 16'h3f80 : 16'h0000)) begin
        errs++; $display("FAIL ones_pe_weight c%0d: got %h", i, pe_weight);
      end
    end
`ifdef BFP16_COL_SCHED_PERF_EN
    vecs++; if (perf_cycles !== 16'd22) begin errs++; $display("FAIL ones_perf: got %0d want 22", perf_cycles); end
`endif
  endtask

  task automatic test_skew();
    logic [15:0] got, want;
    fill_ones();
    xmem[0] = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    @(negedge clk); num_rows = 5'd1; start = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        got  = pe_ifmap[(LANES-1-k)*DW +: DW];
        want = (i == 9 + k) ? 16'(k + 1) : 16'h0000;
        vecs++; if (got !== want) begin errs++; $display("FAIL skew_lane%0d c%0d: got %h want %h", k, i, got, want); end
      end
      vecs++; if (done !== (i == 19)) begin errs++; $display("FAIL skew_done c%0d: got %b", i, done); end
    end
  endtask

  task automatic test_zero();
    @(negedge clk); num_rows = 5'd0; start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i >= 2) start = 1'b0;  // start also held through the done cycle
      vecs++; if (done !== (i == 1)) begin errs++; $display("FAIL zero_done c%0d: got %b want %b", i, done, (i == 1)); end
      vecs++; if (busy !== (i == 1)) begin errs++; $display("FAIL zero_busy c%0d: got %b want %b", i, busy, (i == 1)); end
      vecs++; if ({x_rd_en, res_valid, pe_ctrl} !== 3'b000) begin
        errs++; $display("FAIL zero_quiet c%0d: got %b want 000", i, {x_rd_en, res_valid, pe_ctrl});
      end
      vecs++; if (w_addr !== 3'd0) begin errs++; $display("FAIL zero_w_addr c%0d: got %0d want 0", i, w_addr); end
    end
  endtask

  task automatic test_clamp();
    int nres = 0, nrd = 0, done_at = -1;
    fill_ones();
    @(negedge clk); num_rows = 5'd20; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); start = 1'b0;
      if (x_rd_en) nrd++;
      if (done) done_at = i;
      if (res_valid) begin
        vecs++; if (res_idx !== 4'(nres)) begin errs++; $display("FAIL clamp_idx c%0d: got %0d want %0d", i, res_idx, nres); end
        nres++;
      end
    end
    vecs++; if (nres !== 16) begin errs++; $display("FAIL clamp_res_count: got %0d want 16", nres); end
    vecs++; if (nrd !== 16) begin errs++; $display("FAIL clamp_rd_count: got %0d want 16", nrd); end
    vecs++; if (done_at !== 34) begin errs++; $display("FAIL clamp_done_cycle: got %0d want 34", done_at); end
  endtask

  task automatic test_start_ignored();
    int nres = 0, ndone = 0, done_at = -1;
    @(negedge clk); num_rows = 5'd2; start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 9) begin start = 1'b1; num_rows = 5'd5; end
      else start = 1'b0;
      if (res_valid) nres++;
      if (done) begin ndone++; done_at = i; end
    end
    vecs++; if (ndone !== 1) begin errs++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
    vecs++; if (done_at !== 20) begin errs++; $display("FAIL ign_done_cycle: got %0d want 20", done_at); end
    vecs++; if (nres !== 2) begin errs++; $display("FAIL ign_res_count: got %0d want 2", nres); end
  endtask

  task automatic test_rst_mid();
    fill_ones();
    @(negedge clk); num_rows = 5'd4; start = 1'b1;
    for (int i = 1; i <= 12; i++) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    vecs++; if ({busy, done, x_rd_en, pe_ctrl, res_valid} !== 5'b00000) begin
      errs++; $display("FAIL rstmid_ctrl: got %b want 00000", {busy, done, x_rd_en, pe_ctrl, res_valid});
    end
    vecs++; if ({w_addr, x_addr, res_idx} !== 11'd0) begin
      errs++; $display("FAIL rstmid_addr: got %h want 000", {w_addr, x_addr, res_idx});
    end
    vecs++; if ({pe_weight, res_data} !== 32'h0) begin
      errs++; $display("FAIL rstmid_data: got %h want 00000000", {pe_weight, res_data});
    end
    vecs++; if (pe_ifmap !== 128'h0) begin
      errs++; $display("FAIL rstmid_ifmap: got %h want 0", pe_ifmap);
    end
    rst = 1'b0; num_rows = 5'd1; start = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk); start = 1'b0;
      vecs++; if (res_valid !== (j == 18)) begin errs++; $display("FAIL rstmid_res_valid c%0d: got %b", j, res_valid); end
      vecs++; if (done !== (j == 19)) begin errs++; $display("FAIL rstmid_done c%0d: got %b", j, done); end
      vecs++; if (busy !== (j <= 19)) begin errs++; $display("FAIL rstmid_busy c%0d: got %b", j, busy); end
      if (j == 18) begin
        vecs++; if ({res_idx, res_data} !== {4'd0, 16'h4100}) begin
          errs++; $display("FAIL rstmid_result: got idx %0d data %h want idx 0 data 4100", res_idx, res_data);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_rows = 5'd0;
    fill_ones();
    test_reset();
    test_ones();
    test_skew();
    test_zero();
    test_clamp();
    test_start_ignored();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bfp16_col_sched.md
BFP16_COL_SCHED -- requirements
Module: bfp16_col_sched

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
  DATA_TYPE, 16, element width (bfp16).
  LANES, 8, PE column depth = ifmap lanes = weight vector length.
  MAX_ROWS, 16, maximum rows per job.
  OUT_LAT, 2, cycles from the last lane input of a row to a valid pe_out.
REQ-002 SHALL have ports (one per line: name, direction, width, meaning):
  clk  in  1  clock; one clock domain.
  rst  in  1  reset; synchronous, active-high.
  start  in  1  job request.
  num_rows  in  5  rows M in the job.
  busy  out  1  job in progress.
  done  out  1  one-cycle job-complete pulse.
  w_addr  out  3  weight buffer address.
  w_data  in  16  weight read data; 1-cycle read latency.
  x_rd_en  out  1  ifmap row read strobe.
  x_addr  out  4  ifmap row address.
  x_data  in  LANES*16  ifmap row; lane 0 in MSBs; 1-cycle read latency.
  pe_ctrl  out  1  PE column mode: 0 = weight load, 1 = compute.
  pe_weight  out  16  serial weight to the PE column.
  pe_ifmap  out  LANES*16  skewed ifmap to the PE column; lane 0 in MSBs.
  pe_out  in  16  PE column result.
  res_valid  out  1  result strobe.
  res_idx  out  4  row index of the result.
  res_data  out  16  result value.

Function
REQ-003 SHALL use FSM states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-004 SHALL accept start only in IDLE; this cycle is S. M = min(num_rows, MAX_ROWS). start outside IDLE SHALL be ignored.
REQ-005 SHALL handle M=0 as follows: IDLE->DONE, done pulses at S+1, no buffer reads, pe_ctrl stays 0.
REQ-006 In LOAD_W, SHALL drive w_addr=j in cycle S+j (j=0..7), pe_weight=w_data[j] in cycle S+1+j, and pe_ctrl=0.
REQ-007 In STREAM, SHALL drive x_rd_en=1 and x_addr=r in cycle S+8+r (r=0..M-1); x_rd_en=0 otherwise.
REQ-008 SHALL present element k of row r on pe_ifmap lane k in cycle S+9+r+k, and 0x0000 on every lane slot that carries no valid element.
REQ-009 SHALL drive pe_ctrl=1 from S+9 through the last result cycle, and pe_weight=0x0000 outside LOAD_W.
REQ-010 SHALL pulse res_valid with res_idx=r and res_data=pe_out in cycle S+16+r+OUT_LAT, once per row, rows in order.
REQ-011 SHALL enter DRAIN after the last row read and hold it until the last result; then DONE for one cycle (done=1), then IDLE.
REQ-012 SHALL hold busy=1 from S+1 through the done cycle inclusive; start in the done cycle is ignored.
REQ-013 SHALL reset row, lane and latency counters at job start; no counter wraps within a job.

Reset
REQ-014 On rst, SHALL be in IDLE with all outputs 0 (busy, done, x_rd_en, pe_ctrl, res_valid, addresses, pe_weight, pe_ifmap, res_*), and the skew pipeline cleared.
REQ-015 rst mid-job SHALL abort the job: no done, no further res_valid; start is accepted the cycle after rst deasserts.

Configuration
REQ-016 With BFP16_COL_SCHED_PERF_EN defined, SHALL add output perf_cycles[15:0]. It clears at job start, counts busy cycles, saturates at 0xFFFF, and holds after done. Without the macro, the port and its logic SHALL be absent.

Structure
REQ-017 Package bfp16_pkg SHALL hold DATA_TYPE, LANES, MAX_ROWS and the FSM state typedef.
REQ-018 Lane skewing SHALL be a sub-module bfp16_skew_buf: lane k has a k-stage register delay, and a clear input is driven by rst.

Verification
REQ-019 SHALL cover these directed scenarios:
  Weights all 0x3f80, 4 rows all 0x3f80, reference column model -> res_data=0x4100 for idx 0..3 at S+18..S+21, then done at S+22.
  Row 0 lanes = 0x0001..0x0008 -> lane k shows 0x000(k+1) exactly at S+9+k and 0x0000 at every other cycle.
  num_rows=0 -> done at S+1, no x_rd_en, no res_valid.
  num_rows=20 -> exactly 16 res_valid, with idx 0..15.
  start pulsed during STREAM -> ignored; a single done.
  rst at S+12 -> all outputs 0 next cycle; a new job with M=1 completes normally.
